seq_pattern_gen: RTL

Parametrised, run-time programmable serial pattern generator. It emits a loadable bit pattern of 1 to MAX_LEN bits, MSB first, on a valid/ready stream. It supports cyclic and one-shot modes, plus an optional PRBS7 mode. It replaces the fixed 6-bit "001011" repeater and sits ahead of any bit-serial consumer that can apply backpressure.

---
 rtl/seq_pattern_gen.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: run-time programmable serial bit-pattern generator on a valid/ready stream.
// Optional PRBS7 mode is compiled in when the macro SEQGEN_PRBS_EN is defined.
module seq_pattern_gen #(
    parameter int unsigned        MAX_LEN     = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = 16'h000B,
    parameter int unsigned        DEFAULT_LEN = 6,
    localparam int unsigned       LW          = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic [1:0]         cfg_mode,
    input  logic               start,
    input  logic               stop,
    input  logic               out_ready,
    output logic               out_valid,
    output logic               out_data,
    output logic               out_last,
    output logic               busy,
    output logic               cfg_err
);

    localparam logic [1:0] MODE_CYC  = 2'b00;
    localparam logic [1:0] MODE_ONE  = 2'b01;
    localparam logic [1:0] MODE_PRBS = 2'b10;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state, state_n;
    logic [MAX_LEN-1:0] pat, pat_n, eff_pat_c;
    logic [LW-1:0]      len, len_n, eff_len_c;
    logic [LW-1:0]      idx, idx_n;
    logic [1:0]         mode, mode_n, eff_mode_c;
    logic               valid_n, data_n, last_n, busy_n, err_n;
    logic               load_ok_c, accept_c;
`ifdef SEQGEN_PRBS_EN
    logic [6:0]         lfsr, lfsr_n, cnt, cnt_n, seed_c;
`endif

    // Select pattern bit i without a width-mismatched variable bit-select.
    function automatic logic bit_at(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] i);
        logic [MAX_LEN-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    // Load legality and the configuration a same-cycle start should use.
    always_comb begin
        load_ok_c = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
`ifdef SEQGEN_PRBS_EN
        if (cfg_mode == 2'b11) load_ok_c = 1'b0;
`else
        if (cfg_mode[1]) load_ok_c = 1'b0;
`endif
        if (cfg_load && load_ok_c) begin
            eff_pat_c  = cfg_pattern;
            eff_len_c  = cfg_len;
            eff_mode_c = cfg_mode;
        end else begin
            eff_pat_c  = pat;
            eff_len_c  = len;
            eff_mode_c = mode;
        end
    end

    assign accept_c = out_valid & out_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        pat_n   = pat;
        len_n   = len;
        mode_n  = mode;
        idx_n   = idx;
        valid_n = out_valid;
        data_n  = out_data;
        last_n  = out_last;
        busy_n  = busy;
        err_n   = 1'b0;
`ifdef SEQGEN_PRBS_EN
        lfsr_n  = lfsr;
        cnt_n   = cnt;
        seed_c  = (eff_pat_c[6:0] == 7'd0) ? 7'h7F : eff_pat_c[6:0];
`endif
        case (state)
            IDLE: begin
                if (cfg_load) begin
                    if (load_ok_c) begin
                        pat_n  = cfg_pattern;
                        len_n  = cfg_len;
                        mode_n = cfg_mode;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                if (start && !stop) begin
                    state_n = RUN;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    idx_n   = eff_len_c - LW'(1);
                    data_n  = bit_at(eff_pat_c, idx_n);
                    last_n  = (idx_n == '0);
`ifdef SEQGEN_PRBS_EN
                    if (eff_mode_c == MODE_PRBS) begin
                        lfsr_n = seed_c;
                        cnt_n  = 7'd126;
                        data_n = seed_c[6];
                        last_n = 1'b0;
                    end
`endif
                end
            end
            RUN: begin
                if (stop || (accept_c && (mode == MODE_ONE) && out_last)) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    data_n  = 1'b0;
                    last_n  = 1'b0;
                    busy_n  = 1'b0;
                end else if (accept_c) begin
                    idx_n  = (idx == '0) ? (len - LW'(1)) : (idx - LW'(1));
                    data_n = bit_at(pat, idx_n);
                    last_n = (idx_n == '0);
`ifdef SEQGEN_PRBS_EN
                    // x^7 + x^6 + 1, maximal length 127; cnt marks the period end.
                    if (mode == MODE_PRBS) begin
                        lfsr_n = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                        cnt_n  = (cnt == 7'd0) ? 7'd126 : (cnt - 7'd1);
                        data_n = lfsr_n[6];
                        last_n = (cnt_n == 7'd0);
                    end
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat       <= DEFAULT_PAT;
            len       <= LW'(DEFAULT_LEN);
            mode      <= MODE_CYC;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
`ifdef SEQGEN_PRBS_EN
            lfsr      <= 7'd0;
            cnt       <= 7'd0;
`endif
        end else begin
            state     <= state_n;
            pat       <= pat_n;
            len       <= len_n;
            mode      <= mode_n;
            idx       <= idx_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            out_last  <= last_n;
            busy      <= busy_n;
            cfg_err   <= err_n;
`ifdef SEQGEN_PRBS_EN
            lfsr      <= lfsr_n;
            cnt       <= cnt_n;
`endif
        end
    end

endmodule
